// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings used by the SPRAM slave and its master.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents: HTRANS, HBURST, HSIZE, HPROT and HRESP encodings.
package peripheral_ahb3_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HBURST encodings (only single transfers are generated)
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // HSIZE encodings
  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  // HPROT: data access, privileged, non-bufferable, non-cacheable
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/peripheral_ahb3_spram_master.sv
// AHB3-Lite master: converts a valid/ready request stream into pipelined single transfers.
// Latency: accept at edge T -> NONSEQ after T, data phase after T+1, rsp_valid pulse after T+2.
// Backpressure: req_ready drops while the address slot is stalled by HREADY=0 or an ERROR response.
//
// Ports:
//   HCLK, HRESETn              clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake; req_write/addr/size/wdata are the attributes
//   rsp_valid/rsp_rdata/error  one-cycle in-order response pulse, no backpressure
//   H*                         AHB3-Lite master bus (all outputs registered or constant)
module peripheral_ahb3_spram_master
  import peripheral_ahb3_pkg::*;
#(
  parameter int PLEN = 8,
  parameter int XLEN = 32
) (
  input  logic            HCLK,
  input  logic            HRESETn,

  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [PLEN-1:0] req_addr,
  input  logic [2:0]      req_size,
  input  logic [XLEN-1:0] req_wdata,

  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error,

  output logic [PLEN-1:0] HADDR,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic            HMASTLOCK,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  input  logic            HREADY,
  input  logic            HRESP
);

  // Address slot: HADDR/HWRITE/HSIZE double as the slot's attribute registers,
  // so only the valid flag and the write data need separate storage.
  logic            a_valid;
  logic [XLEN-1:0] a_wdata;

  // Data slot: HWDATA doubles as the slot's write data.
  logic            d_valid;
  logic            d_write;

  // Set during the first cycle of a two-cycle ERROR response; keeps the
  // pending address phase parked (HTRANS=IDLE) until the error completes.
  logic            err_hold;

  logic            accept;
  logic            a_move;
  logic            d_done;
  logic            err_first;
  logic            a_valid_nxt;
  logic            force_idle;

  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;

  // Ready depends only on slot state and bus status, never on req_valid.
  assign req_ready = !a_valid || (HREADY && !err_hold);
  assign accept    = req_valid && req_ready;

  // The address phase is only taken by the slave while NONSEQ is on the bus;
  // during the error recovery cycle HTRANS is IDLE and the slot stays put.
  assign a_move    = a_valid && HREADY && (HTRANS == HTRANS_NONSEQ);
  assign d_done    = d_valid && HREADY;
  assign err_first = d_valid && (HRESP == HRESP_ERROR) && !HREADY;

  assign a_valid_nxt = accept || (a_valid && !a_move);

  // IDLE must be on the bus in the second error cycle, even if a request
  // was accepted into an empty slot during the first one.
  assign force_idle = err_first || (err_hold && !HREADY);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid   <= 1'b0;
      a_wdata   <= '0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      err_hold  <= 1'b0;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= HSIZE_BYTE;
      HTRANS    <= HTRANS_IDLE;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      // Address slot
      a_valid <= a_valid_nxt;
      if (accept) begin
        HADDR   <= req_addr;
        HWRITE  <= req_write;
        HSIZE   <= req_size;
        a_wdata <= req_wdata;
      end

      if (force_idle) begin
        HTRANS <= HTRANS_IDLE;
      end else begin
        HTRANS <= a_valid_nxt ? HTRANS_NONSEQ : HTRANS_IDLE;
      end

      // Data slot: refilled by the address slot on the same edge it drains.
      d_valid <= a_move || (d_valid && !d_done);
      if (a_move) begin
        d_write <= HWRITE;
        HWDATA  <= a_wdata;
      end

      // Error recovery
      if (err_first) begin
        err_hold <= 1'b1;
      end else if (err_hold && HREADY) begin
        err_hold <= 1'b0;
      end

      // Response pulse, one cycle after the data phase completes.
      rsp_valid <= d_done;
      rsp_error <= d_done && (HRESP == HRESP_ERROR);
      if (d_done) begin
        rsp_rdata <= d_write ? '0 : HRDATA;
      end
    end
  end

endmodule

// File: doc/peripheral_ahb3_spram_master.md
# peripheral_ahb3_spram_master

Single-clock AHB3-Lite master that turns a simple valid/ready request stream into pipelined single transfers for the `peripheral_ahb3_spram` slave. It sits directly upstream of that slave, with HSEL tied high at the top level in point-to-point use. It overlaps the address phase of transfer N+1 with the data phase of transfer N, inserts nothing on wait states, and returns one response per request in order.

## Interface
Parameters:
- PLEN, 8, address width.
- XLEN, 32, data width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- HCLK  input  1  clock.
- HRESETn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when valid&ready.
- req_write  input  1  1=write, 0=read.
- req_addr  input  PLEN  byte address.
- req_size  input  3  HSIZE encoding: 0=byte, 1=half, 2=word.
- req_wdata  input  XLEN  write data, already lane-aligned.
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_rdata  output  XLEN  read data; 0 for writes.
- rsp_error  output  1  slave returned ERROR.
- HADDR  output  PLEN  registered.
- HWRITE  output  1  registered.
- HSIZE  output  3  registered.
- HBURST  output  3  constant SINGLE (3'b000).
- HPROT  output  4  constant 4'b0011.
- HTRANS  output  2  IDLE (00) or NONSEQ (10) only.
- HMASTLOCK  output  1  constant 0.
- HWDATA  output  XLEN  registered, valid during the data phase.
- HRDATA  input  XLEN  slave read data.
- HREADY  input  1  bus ready (slave HREADYOUT).
- HRESP  input  1  0=OKAY, 1=ERROR.

## Operation
- Two pipeline slots:
  - A: address phase. Holds a_valid, addr, write, size, wdata.
  - D: data phase. Holds d_valid, write, wdata.
- req_ready = !a_valid || (HREADY && !err_hold). It is combinational, with no dependence on req_valid.
- Accept: load slot A and drive HTRANS=NONSEQ from the next cycle.
- A→D move: when a_valid && HREADY && HTRANS==NONSEQ.
  - D takes A's write flag.
  - HWDATA takes A's wdata.
  - If a new request is accepted in the same cycle, A reloads; otherwise a_valid clears and HTRANS becomes IDLE.
- D completion: when d_valid && HREADY.
  - Next cycle: rsp_valid=1, rsp_error=HRESP, rsp_rdata=HRDATA for reads and 0 for writes.
  - d_valid clears unless refilled from A in the same cycle.
- ERROR handling:
  - First error cycle (d_valid, HRESP=1, HREADY=0): set err_hold. HTRANS is forced to IDLE next cycle, and HADDR/HWRITE/HSIZE hold.
  - Second error cycle (HRESP=1, HREADY=1): D completes with rsp_error=1. The pending A transfer is not lost: err_hold clears, and NONSEQ is reissued the following cycle with the same attributes.
- Wait states (HREADY=0, HRESP=0): all H* outputs and both slots hold; req_ready=0 if a_valid.
- Reset (mid-transfer included): both slots and err_hold clear immediately. Any in-flight transfer is dropped without a response.
- Reset values:
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - req_ready=1.

## Timing
- Zero-wait latency: request accepted at edge T gives NONSEQ in cycle T+1, data phase in cycle T+2, and rsp_valid in cycle T+3.
- Throughput: one transfer per cycle back-to-back, with responses in request order.
- Each wait cycle adds one cycle to the affected transfer and stalls the one behind it.
- ERROR adds one cycle for the errored transfer and one reissue cycle for the pending transfer.
- H* outputs change only on HCLK edges and are never combinational from req_*.

## Structure
- Shared package peripheral_ahb3_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HBURST_SINGLE.
  - HSIZE_BYTE/HWORD/WORD.
  - HPROT_DATA_PRIV (4'b0011).
  - HRESP_OKAY/ERROR.
- The slave already uses the same constants from this package.
- Single module with no sub-module; the slot registers are small enough to keep inline.

## Test plan
- Reset, then request {write, 0x10, size 2, 0xDEADBEEF}, then a read of 0x10 against the SPRAM: HTRANS NONSEQ at T+1, HWDATA=0xDEADBEEF at T+2, read rsp_rdata=0xDEADBEEF with rsp_error=0.
- Eight back-to-back writes to 0x00..0x1C followed by eight reads: HTRANS NONSEQ every cycle, eight rsp pulses on consecutive cycles, data matching.
- Slave inserts 3 wait states on the 2nd of 3 queued reads: H* stable during the waits, req_ready=0, responses in order, total 3 cycles later than zero-wait.
- ERROR on a write to 0xFC while a read of 0x04 is pending in A: HTRANS=IDLE in the 2nd error cycle, rsp_error=1 for the write, read reissued and returning OKAY data.
- HRESETn asserted while a write is in the data phase: all outputs at reset values asynchronously, no rsp_valid, next request after release completing normally.
- Byte write 0xAA at 0x03 (size 0, wdata 0xAA000000), then word read of 0x00: HSIZE=0 on the bus, and the read returns the byte in lane 3 with other bytes unchanged.
